// File: rtl/nand2_bist_if.sv
// Pin bundle between the NAND2 self-test engine and the gate under test / controlling host.
// The slave side is the BIST engine; the master side is whoever starts runs and models the gate.
interface nand2_bist_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             dut_a1;
    logic             dut_a2;
    logic             dut_zn;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       fail_vec;
    logic [ERR_W-1:0] err_count;

    modport slave (
        input  start,
        input  dut_zn,
        output dut_a1,
        output dut_a2,
        output busy,
        output done,
        output pass,
        output fail_vec,
        output err_count
    );

    modport master (
        output start,
        output dut_zn,
        input  dut_a1,
        input  dut_a2,
        input  busy,
        input  done,
        input  pass,
        input  fail_vec,
        input  err_count
    );
endinterface

// File: rtl/nand2_bist.sv
// Self-test driver/checker for a single NAND2: sweeps the truth table NUM_PASSES times,
// samples ZN after a settle window and accumulates sticky per-pattern and counted mismatches.
module nand2_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 4,
    parameter int ERR_W         = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    nand2_bist_if.slave  bus
);
    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       pat_q, pat_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       fail_q, fail_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             expected;
    logic             mismatch;

    // Pattern index doubles as the pin drive, so the pins only move when the index does.
    assign bus.dut_a1    = pat_q[1];
    assign bus.dut_a2    = pat_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_vec  = fail_q;
    assign bus.err_count = err_q;

    // Case-equality makes an X/Z on ZN count as a mismatch.
    assign expected = ~(pat_q[1] & pat_q[0]);
    assign mismatch = (bus.dut_zn === expected) ? 1'b0 : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pat_q    <= 2'b00;
            settle_q <= '0;
            pcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 4'b0000;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            settle_q <= settle_d;
            pcnt_q   <= pcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        settle_d = settle_q;
        pcnt_d   = pcnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    pat_d    = 2'b00;
                    settle_d = '0;
                    pcnt_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    fail_d   = 4'b0000;
                    err_d    = '0;
                end
            end
            RUN: begin
                if (settle_q == SW'(SETTLE_CYCLES)) begin
                    if (mismatch) begin
                        fail_d[pat_q] = 1'b1;
                        if (err_q != '1)
                            err_d = err_q + 1'b1;
                    end
                    settle_d = '0;
                    pat_d    = pat_q + 2'd1;
                    if (pat_q == 2'b11) begin
                        if (pcnt_q == PW'(NUM_PASSES - 1)) begin
                            // Verdict includes the mismatch from this final sample.
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_d == '0);
                            pcnt_d  = '0;
                        end else begin
                            pcnt_d = pcnt_q + 1'b1;
                        end
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_nand2_bist.sv
// Directed bench for nand2_bist: ideal and faulty gate models, saturation, ignored starts, mid-run reset.
module tb_nand2_bist;
    logic clk;
    logic rst_n;
    int   mode;      // 0 ideal NAND, 1 ZN stuck-at-1, 2 ZN stuck-at-0, 3 AND gate
    int   checks;
    int   failures;
    int   cyc;
    bit   seq_ok;

    nand2_bist_if #(.ERR_W(8)) bus ();
    nand2_bist_if #(.ERR_W(3)) bus_sat ();

    nand2_bist #(.SETTLE_CYCLES(2), .NUM_PASSES(4), .ERR_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    nand2_bist #(.SETTLE_CYCLES(2), .NUM_PASSES(4), .ERR_W(3)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat)
    );

    function automatic logic zn_model(input logic a1, input logic a2, input int m);
        case (m)
            0:       return ~(a1 & a2);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return a1 & a2;
        endcase
    endfunction

    assign bus.dut_zn     = zn_model(bus.dut_a1, bus.dut_a2, mode);
    assign bus_sat.dut_zn = zn_model(bus_sat.dut_a1, bus_sat.dut_a2, mode);
    assign bus_sat.start  = bus.start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulses start, then counts busy cycles at negedges while checking the pin sequence.
    task automatic run(input int p1, input int p2, input int rst_at,
                       output int n, output bit ok);
        logic [1:0] e;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n  = 0;
        ok = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (!bus.busy) break;
            e = 2'((n / 3) % 4);
            if ({bus.dut_a1, bus.dut_a2} !== e) ok = 1'b0;
            n++;
            if (n == rst_at) begin
                rst_n = 1'b0;
                break;
            end
            bus.start = (n == p1) || (n == p2);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        mode      = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pass", 32'(bus.pass), 32'd0);
        check("rst_pins", 32'({bus.dut_a1, bus.dut_a2}), 32'd0);
        check("rst_err",  32'(bus.err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal gate
        run(-1, -1, -1, cyc, seq_ok);
        check("ideal_cycles", 32'(cyc), 32'd48);
        check("ideal_seq",    32'(seq_ok), 32'd1);
        check("ideal_done",   32'(bus.done), 32'd1);
        check("ideal_pass",   32'(bus.pass), 32'd1);
        check("ideal_fvec",   32'(bus.fail_vec), 32'd0);
        check("ideal_err",    32'(bus.err_count), 32'd0);
        check("ideal_pins",   32'({bus.dut_a1, bus.dut_a2}), 32'd0);

        // ZN stuck-at-1: only pattern 11 fails, once per pass
        mode = 1;
        run(-1, -1, -1, cyc, seq_ok);
        check("sa1_cycles", 32'(cyc), 32'd48);
        check("sa1_pass",   32'(bus.pass), 32'd0);
        check("sa1_fvec",   32'(bus.fail_vec), 32'h8);
        check("sa1_err",    32'(bus.err_count), 32'd4);

        // ZN stuck-at-0: patterns 00/01/10 fail; 3-bit counter saturates at 7
        mode = 2;
        run(-1, -1, -1, cyc, seq_ok);
        check("sa0_fvec",     32'(bus.fail_vec), 32'h7);
        check("sa0_err",      32'(bus.err_count), 32'd12);
        check("sa0_sat_err",  32'(bus_sat.err_count), 32'd7);
        check("sa0_sat_fvec", 32'(bus_sat.fail_vec), 32'h7);
        check("sa0_sat_done", 32'(bus_sat.done), 32'd1);

        // AND gate: every pattern fails every pass
        mode = 3;
        run(-1, -1, -1, cyc, seq_ok);
        check("and_fvec", 32'(bus.fail_vec), 32'hF);
        check("and_err",  32'(bus.err_count), 32'd16);
        check("and_pass", 32'(bus.pass), 32'd0);

        // Restart from DONE clears results; ideal gate again
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("restart_done", 32'(bus.done), 32'd0);
        check("restart_err",  32'(bus.err_count), 32'd0);
        check("restart_fvec", 32'(bus.fail_vec), 32'd0);
        check("restart_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < 200 && bus.busy; k++) @(negedge clk);
        check("restart_pass", 32'(bus.pass), 32'd1);
        check("restart_err2", 32'(bus.err_count), 32'd0);

        // Starts during a run are ignored
        run(5, 30, -1, cyc, seq_ok);
        check("ign_cycles", 32'(cyc), 32'd48);
        check("ign_seq",    32'(seq_ok), 32'd1);
        check("ign_pass",   32'(bus.pass), 32'd1);

        // Mid-run reset with a faulty gate
        mode = 2;
        run(-1, -1, 20, cyc, seq_ok);
        #1;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.done), 32'd0);
        check("mrst_pass", 32'(bus.pass), 32'd0);
        check("mrst_err",  32'(bus.err_count), 32'd0);
        check("mrst_fvec", 32'(bus.fail_vec), 32'd0);
        check("mrst_pins", 32'({bus.dut_a1, bus.dut_a2}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_idle_done", 32'(bus.done), 32'd0);
        run(-1, -1, -1, cyc, seq_ok);
        check("fresh_cycles", 32'(cyc), 32'd48);
        check("fresh_seq",    32'(seq_ok), 32'd1);
        check("fresh_err",    32'(bus.err_count), 32'd12);
        check("fresh_fvec",   32'(bus.fail_vec), 32'h7);
        check("fresh_pass",   32'(bus.pass), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nand2_bist.md
Name: nand2_bist

Overview:
- Self-test driver and checker for the single-NAND2 netlist top. It sits on the far side of that netlist's pins and drives its two inputs, A1 and A2.
- Steps the full 2-input truth table, samples the ZN output after a settle window, and compares it against the expected NAND value.
- Reports per-pattern sticky failures, a saturating error count and a pass/done summary.
- Used in sim and on silicon bring-up to confirm that the mapped nand2x1_sc instance matches the gate-level timing runs.

Parameters:
- SETTLE_CYCLES, 2, extra cycles each pattern is held before ZN is sampled; legal range >=1.
- NUM_PASSES, 4, number of full truth-table sweeps per run; legal range >=1.
- ERR_W, 8, width of the err_count output.

Ports:
- clk  in  1  the block's single clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  single-cycle run request, sampled high in IDLE or DONE.
- dut_a1  out  1  drives NAND input A1; registered output.
- dut_a2  out  1  drives NAND input A2; registered output.
- dut_zn  in  1  NAND output ZN, sampled directly with no synchroniser (same clock domain).
- busy  out  1  high while a run is in progress.
- done  out  1  level; high from run completion until the next accepted start.
- pass  out  1  valid while done=1; high iff err_count==0.
- fail_vec  out  4  sticky per-pattern failure flags; bit index = {a1,a2}.
- err_count  out  ERR_W  total mismatches; saturates at all-ones.

Behaviour:
- Reset (async on rst_n low): state=IDLE. dut_a1=dut_a2=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0. Internal pattern index, pass counter and settle counter all =0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Next edge enters RUN.
  - Clears fail_vec, err_count, done and pass.
  - Sets busy=1.
  - Loads pattern index 0, so {dut_a1,dut_a2}=2'b00.
  - Clears the settle and pass counters.
- RUN, per pattern:
  - Each pattern is held for exactly SETTLE_CYCLES+1 cycles.
  - The settle counter counts 0..SETTLE_CYCLES.
  - On the edge where the counter==SETTLE_CYCLES, dut_zn is sampled and compared with expected = ~(dut_a1 & dut_a2).
- On a mismatch at that edge:
  - fail_vec[{dut_a1,dut_a2}] is set.
  - err_count increments, but holds once it reaches 2^ERR_W-1.
- Pattern advance, on the same sampling edge:
  - Pattern index increments in the order 00, 01, 10, 11 and the settle counter clears.
  - After pattern 11, the pass counter increments and the index wraps to 00.
- Run end: when pattern 11 of pass NUM_PASSES-1 is sampled, the next state is DONE.
  - busy=0, done=1.
  - pass = (final err_count==0), including any mismatch from that last sample.
  - dut_a1/dut_a2 return to 0.
- Run length: NUM_PASSES*4*(SETTLE_CYCLES+1) cycles with busy=1. Default = 48.
- start while busy=1 is ignored, with no effect on counters or results.
- DONE holds every result until the next accepted start. A start in DONE restarts the run exactly as from IDLE.
- dut_a1/dut_a2 only change on the sampling edge (pattern change), so each pattern is applied glitch-free for its whole window.
- Reset asserted mid-run aborts immediately to the reset values above. No result is retained.
- An X/Z on dut_zn at a sampling edge is treated as a mismatch.

Test Plan:
- Ideal NAND model, defaults, one start pulse:
  - busy high for 48 cycles; the a1/a2 sequence is 00,01,10,11 repeated 4 times, each held 3 cycles.
  - Then done=1, pass=1, fail_vec=4'b0000, err_count=0.
- ZN stuck-at-1: done after 48 cycles, pass=0, fail_vec=4'b1000, err_count=4.
- ZN stuck-at-0: fail_vec=4'b0111, err_count=12.
  - Rerun with ERR_W=3: err_count saturates at 7 and fail_vec is unchanged.
- DUT replaced by an AND gate:
  - fail_vec=4'b1111, err_count=16, pass=0.
  - A second start in DONE clears the results. With the ideal model swapped back in, the rerun ends with pass=1 and err_count=0.
- Ideal model, extra start pulses at cycles 5 and 30 of a run:
  - Both are ignored; the run still ends after exactly 48 busy cycles with pass=1.
- Faulty (stuck-at-0) model, rst_n pulsed low at cycle 20:
  - All outputs return to their reset values within the reset assertion.
  - State is IDLE and done=0.
  - A following start gives a complete, fresh 48-cycle run.
